// File: rtl/synapse_loader.sv
// synapse_loader
//   Loads neuron configuration from a byte-wide command stream, then runs the
//   neuron for a programmed number of steps while counting output spikes.
//
//   Parameters
//     SYNAPSES        synapse count (multiple of 8)
//     THRESHOLD_BITS  threshold width (<= 7)
//
//   Ports
//     clk, reset          rising-edge clock, synchronous active-high reset
//     in_valid/in_ready   command handshake (ready only in IDLE)
//     in_cmd, in_data     opcode (0 WEIGHT, 1 INPUT, 2 PARAM, 3 RUN) + payload
//     weights, inputs     synapse weight / spike bit vectors to the neuron
//     shift, threshold    decay shift and spike threshold to the neuron
//     neuron_enable       membrane update strobe, high every RUN cycle
//     is_spike            same-cycle spike flag from the neuron
//     busy, done          run in progress / one-cycle end-of-run pulse
//     spike_count         spikes seen during the last run (saturating)
//
//   Build option
//     SYNAPSE_LOADER_SPIKE_COUNT_EN  implements the spike counter; when
//     undefined spike_count is tied to 0.
module synapse_loader #(
   parameter int SYNAPSES       = 32,
   parameter int THRESHOLD_BITS = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                in_cmd,
   input  logic [7:0]                in_data,
   output logic [SYNAPSES-1:0]       weights,
   output logic [SYNAPSES-1:0]       inputs,
   output logic [2:0]                shift,
   output logic [THRESHOLD_BITS-1:0] threshold,
   output logic                      neuron_enable,
   input  logic                      is_spike,
   output logic                      busy,
   output logic                      done,
   output logic [7:0]                spike_count
);

   localparam logic [1:0] CMD_WEIGHT = 2'd0;
   localparam logic [1:0] CMD_INPUT  = 2'd1;
   localparam logic [1:0] CMD_PARAM  = 2'd2;
   localparam logic [1:0] CMD_RUN    = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t     state, state_nxt;
   logic [8:0] steps;     // 1..256 remaining steps while in RUN
   logic       accept;

   // Newest byte enters at the top; the concatenation form also works
   // when SYNAPSES is exactly 8.
   logic [SYNAPSES+7:0] weights_cat, inputs_cat;
   assign weights_cat = {in_data, weights};
   assign inputs_cat  = {in_data, inputs};

   assign accept = in_valid && in_ready;

   always_comb begin
      state_nxt     = state;
      in_ready      = 1'b0;
      neuron_enable = 1'b0;
      done          = 1'b0;
      busy          = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = !reset;
            if (accept && in_cmd == CMD_RUN) state_nxt = S_RUN;
         end
         S_RUN: begin
            neuron_enable = !reset;
            busy          = !reset;
            if (steps == 9'd1) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = !reset;
            busy      = !reset;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         steps     <= '0;
         weights   <= '0;
         inputs    <= '0;
         shift     <= '0;
         threshold <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            case (in_cmd)
               CMD_WEIGHT: weights <= weights_cat[SYNAPSES+7:8];
               CMD_INPUT:  inputs  <= inputs_cat[SYNAPSES+7:8];
               CMD_PARAM: begin
                  if (in_data[7]) shift     <= in_data[2:0];
                  else            threshold <= in_data[THRESHOLD_BITS-1:0];
               end
               default: steps <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            endcase
         end else if (state == S_RUN) begin
            steps <= steps - 9'd1;
         end
      end
   end

`ifdef SYNAPSE_LOADER_SPIKE_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         spike_count <= '0;
      else if (accept && in_cmd == CMD_RUN)
         spike_count <= '0;
      else if (neuron_enable && is_spike && spike_count != 8'hFF)
         spike_count <= spike_count + 8'd1;
   end
`else
   logic unused_is_spike;
   assign unused_is_spike = is_spike;
   assign spike_count     = '0;
`endif

endmodule

// File: tb/tb_synapse_loader.sv
module tb_synapse_loader;
   localparam int SYN = 32;
   localparam int TB  = 6;
   localparam int NB  = SYN / 8;

   logic           clk = 1'b0;
   logic           reset, in_valid, is_spike;
   logic [1:0]     in_cmd;
   logic [7:0]     in_data;
   logic           in_ready, neuron_enable, busy, done;
   logic [SYN-1:0] weights, inputs;
   logic [2:0]     shift;
   logic [TB-1:0]  threshold;
   logic [7:0]     spike_count;

   synapse_loader #(.SYNAPSES(SYN), .THRESHOLD_BITS(TB)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_cmd(in_cmd), .in_data(in_data), .weights(weights), .inputs(inputs),
      .shift(shift), .threshold(threshold), .neuron_enable(neuron_enable),
      .is_spike(is_spike), .busy(busy), .done(done), .spike_count(spike_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: the last NB bytes of each stream, plus scalar params.
   logic [7:0]    wq[$];
   logic [7:0]    iq[$];
   logic [2:0]    m_shift;
   logic [TB-1:0] m_thr;
   int            m_cnt;

   function automatic logic [SYN-1:0] pack(input logic [7:0] q[$]);
      logic [SYN-1:0] r;
      r = '0;
      for (int i = 0; i < NB; i++) begin
         int idx;
         idx = q.size() - NB + i;
         if (idx >= 0) r[i*8 +: 8] = q[idx];
      end
      return r;
   endfunction

   function automatic logic [7:0] exp_count();
`ifdef SYNAPSE_LOADER_SPIKE_COUNT_EN
      return 8'(m_cnt);
`else
      return 8'd0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic model_reset();
      wq.delete(); iq.delete();
      m_shift = '0; m_thr = '0; m_cnt = 0;
   endtask

   task automatic model_cmd(input logic [1:0] c, input logic [7:0] d);
      case (c)
         2'd0: begin wq.push_back(d); if (wq.size() > NB) void'(wq.pop_front()); end
         2'd1: begin iq.push_back(d); if (iq.size() > NB) void'(iq.pop_front()); end
         2'd2: if (d[7]) m_shift = d[2:0]; else m_thr = d[TB-1:0];
         default: ;
      endcase
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".weights"},   weights,   pack(wq));
      chk({tag, ".inputs"},    inputs,    pack(iq));
      chk({tag, ".shift"},     shift,     m_shift);
      chk({tag, ".threshold"}, threshold, m_thr);
   endtask

   task automatic send(input logic [1:0] c, input logic [7:0] d);
      in_valid = 1'b1; in_cmd = c; in_data = d;
      #1;
      chk("send.in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      model_cmd(c, d);
   endtask

   // mode 0: random spikes, 1: always spiking, 2: exactly two spikes.
   task automatic run(input logic [7:0] n_cmd, input int mode,
                      input bit hold_w, input logic [7:0] hw_data);
      int n, p1, p2;
      n = (n_cmd == 8'd0) ? 256 : int'(n_cmd);
      p1 = $urandom_range(1, n);
      p2 = p1;
      while (p2 == p1 && n > 1) p2 = $urandom_range(1, n);
      send(2'd3, n_cmd);
      m_cnt = 0;
      if (hold_w) begin in_valid = 1'b1; in_cmd = 2'd0; in_data = hw_data; end
      for (int k = 1; k <= n; k++) begin
         case (mode)
            1:       is_spike = 1'b1;
            2:       is_spike = (k == p1 || k == p2);
            default: is_spike = 1'($urandom);
         endcase
         #1;
         chk("run.enable",   neuron_enable, 1'b1);
         chk("run.done",     done,          1'b0);
         chk("run.in_ready", in_ready,      1'b0);
         chk("run.busy",     busy,          1'b1);
         if (k == 1 || k == n) check_regs("run");
         if (is_spike && m_cnt < 255) m_cnt++;
         tick();
      end
      is_spike = 1'($urandom);
      #1;
      chk("done.enable",   neuron_enable, 1'b0);
      chk("done.done",     done,          1'b1);
      chk("done.busy",     busy,          1'b1);
      chk("done.in_ready", in_ready,      1'b0);
      chk("done.count",    spike_count,   exp_count());
      check_regs("done");
      tick();
      is_spike = 1'b0;
      #1;
      chk("idle.in_ready", in_ready,      1'b1);
      chk("idle.done",     done,          1'b0);
      chk("idle.busy",     busy,          1'b0);
      chk("idle.enable",   neuron_enable, 1'b0);
      chk("idle.count",    spike_count,   exp_count());
      if (hold_w) begin
         tick();
         in_valid = 1'b0;
         model_cmd(2'd0, hw_data);
         #1;
         check_regs("held_weight");
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_cmd = '0; in_data = '0; is_spike = 1'b0;
      model_reset();
      tick();
      chk("rst.in_ready", in_ready,      1'b0);
      chk("rst.enable",   neuron_enable, 1'b0);
      chk("rst.done",     done,          1'b0);
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst.in_ready", in_ready,    1'b1);
      chk("post_rst.count",    spike_count, 8'd0);
      check_regs("post_rst");

      // weight byte ordering
      send(2'd0, 8'h11); send(2'd0, 8'h22); send(2'd0, 8'h33); send(2'd0, 8'h44);
      #1;
      chk("weights_const", weights, 32'h44332211);
      for (int i = 0; i < NB; i++) send(2'd1, 8'($urandom));

      // parameters
      send(2'd2, 8'h05); send(2'd2, 8'h83);
      #1;
      chk("thr_const",   threshold, 6'd5);
      chk("shift_const", shift,     3'd3);
      check_regs("params");

      run(8'd4, 2, 1'b0, 8'h00);   // two spikes in four steps
      run(8'd0, 1, 1'b0, 8'h00);   // 256 steps, saturating count
      run(8'd3, 0, 1'b1, 8'($urandom)); // WEIGHT held during run

      // random configuration traffic interleaved with short runs
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < 5; j++) send(2'($urandom_range(0, 2)), 8'($urandom));
         run(8'($urandom_range(1, 20)), 0, 1'b0, 8'h00);
      end

      // reset on the third RUN cycle aborts the run
      send(2'd3, 8'd8);
      tick(); tick();
      reset = 1'b1;
      #1;
      chk("abort.enable",   neuron_enable, 1'b0);
      chk("abort.done",     done,          1'b0);
      chk("abort.in_ready", in_ready,      1'b0);
      tick();
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("abort.post_enable", neuron_enable, 1'b0);
         chk("abort.post_done",   done,          1'b0);
         chk("abort.post_ready",  in_ready,      1'b1);
         chk("abort.post_count",  spike_count,   8'd0);
         if (k == 0) check_regs("abort.post");
         tick();
      end
      run(8'($urandom_range(1, 10)), 0, 1'b0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
